// File: rtl/word_splitter_pkg.sv
// Shared types and widths for the 64-to-32 bit word splitter.
package word_splitter_pkg;

    localparam int IN_W  = 64;
    localparam int OUT_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    // Selects the upper (upper = 1) or lower half of a full-width word.
    function automatic logic [OUT_W-1:0] word_half(input logic [IN_W-1:0] word,
                                                   input logic upper);
        return upper ? word[IN_W-1:OUT_W] : word[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/word_splitter_fifo.sv
// Synchronous FIFO buffering full-width words ahead of the splitter FSM.
// Head data is read combinationally so a pop can load it in the same cycle.
module word_splitter_fifo
    import word_splitter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = IN_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];
    assign level   = level_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/word_splitter.sv
// Buffers 64-bit strobed words and serialises each into two 32-bit beats.
// Define WORD_SPLITTER_HIGH_FIRST_EN to send the upper half first.
module word_splitter
    import word_splitter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IN_W-1:0]        din,
    input  logic                   din_available,
    output logic [OUT_W-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    input  logic                   clear_overflow
);

`ifdef WORD_SPLITTER_HIGH_FIRST_EN
    localparam logic FIRST_UPPER  = 1'b1;
`else
    localparam logic FIRST_UPPER  = 1'b0;
`endif
    localparam logic SECOND_UPPER = !FIRST_UPPER;

    state_t           state_reg;
    state_t           state_next;
    logic [IN_W-1:0]  hold_reg;
    logic [IN_W-1:0]  hold_next;
    logic [OUT_W-1:0] dout_reg;
    logic [OUT_W-1:0] dout_next;
    logic             dout_valid_reg;
    logic             dout_valid_next;
    logic             overflow_reg;
    logic             overflow_next;

    logic             fifo_push;
    logic             fifo_pop;
    logic [IN_W-1:0]  fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    // Fullness is judged on the registered level, so a same-cycle pop never rescues a word.
    assign drop      = din_available && fifo_full;
    assign fifo_push = din_available && !fifo_full;

    word_splitter_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IN_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (din),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty) state_next = FIRST;
            FIRST:   if (dout_ready)  state_next = SECOND;
            SECOND:  if (dout_ready)  state_next = fifo_empty ? IDLE : FIRST;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop        = 1'b0;
        hold_next       = hold_reg;
        dout_next       = dout_reg;
        dout_valid_next = dout_valid_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop        = 1'b1;
                    hold_next       = fifo_head;
                    dout_next       = word_half(fifo_head, FIRST_UPPER);
                    dout_valid_next = 1'b1;
                end else begin
                    dout_valid_next = 1'b0;
                end
            end
            FIRST: begin
                if (dout_ready) begin
                    dout_next = word_half(hold_reg, SECOND_UPPER);
                end
            end
            SECOND: begin
                // Chain straight into the next word so back-to-back beats have no bubble.
                if (dout_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop        = 1'b1;
                        hold_next       = fifo_head;
                        dout_next       = word_half(fifo_head, FIRST_UPPER);
                        dout_valid_next = 1'b1;
                    end else begin
                        dout_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                dout_valid_next = 1'b0;
            end
        endcase
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clear_overflow) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg       <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            hold_reg       <= hold_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_word_splitter.sv
// Directed testbench for word_splitter with DEPTH = 4; expected beat order follows
// WORD_SPLITTER_HIGH_FIRST_EN.
module tb_word_splitter;

    logic        clk;
    logic        reset;
    logic [63:0] din;
    logic        din_available;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        clear_overflow;

    int tests_run;
    int tests_failed;

    logic [63:0] words [6];

    word_splitter #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .din_available  (din_available),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] beat(input logic [63:0] w, input int k);
`ifdef WORD_SPLITTER_HIGH_FIRST_EN
        return (k == 0) ? w[63:32] : w[31:0];
`else
        return (k == 0) ? w[31:0] : w[63:32];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [63:0] w);
        din           = w;
        din_available = 1'b1;
        tick();
        din_available = 1'b0;
    endtask

    // Expects FIRST with beat 0 of words[first] on dout and dout_ready high.
    task automatic drain(input int first, input int count, input string tag);
        for (int w = first; w < first + count; w++) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("%s_valid_w%0d_b%0d", tag, w, k), 64'(dout_valid), 64'd1);
                check($sformatf("%s_dout_w%0d_b%0d", tag, w, k), 64'(dout), 64'(beat(words[w], k)));
                tick();
            end
        end
        check({tag, "_valid_end"}, 64'(dout_valid), 64'd0);
        check({tag, "_level_end"}, 64'(fifo_level), 64'd0);
    endtask

    task automatic run_single(input string tag);
        logic [63:0] w;
        w             = 64'h11223344_AABBCCDD;
        dout_ready    = 1'b1;
        din           = w;
        din_available = 1'b1;
        tick();
        din_available = 1'b0;
        check({tag, "_n1_valid"}, 64'(dout_valid), 64'd0);
        check({tag, "_n1_level"}, 64'(fifo_level), 64'd1);
        tick();
        check({tag, "_n2_valid"}, 64'(dout_valid), 64'd1);
        check({tag, "_n2_dout"}, 64'(dout), 64'(beat(w, 0)));
        check({tag, "_n2_level"}, 64'(fifo_level), 64'd0);
        tick();
        check({tag, "_n3_valid"}, 64'(dout_valid), 64'd1);
        check({tag, "_n3_dout"}, 64'(dout), 64'(beat(w, 1)));
        tick();
        check({tag, "_n4_valid"}, 64'(dout_valid), 64'd0);
        check({tag, "_n4_dout_kept"}, 64'(dout), 64'(beat(w, 1)));
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        words[0]       = 64'h0101_0101_A0A0_A0A0;
        words[1]       = 64'h0202_0202_B1B1_B1B1;
        words[2]       = 64'h0303_0303_C2C2_C2C2;
        words[3]       = 64'h0404_0404_D3D3_D3D3;
        words[4]       = 64'h0505_0505_E4E4_E4E4;
        words[5]       = 64'h0606_0606_F5F5_F5F5;
        reset          = 1'b0;
        din            = '0;
        din_available  = 1'b0;
        dout_ready     = 1'b0;
        clear_overflow = 1'b0;

        repeat (3) tick();
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        run_single("single");

        // Backpressure: four words, first one lands in hold.
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(words[i]);
        check("bp_level", 64'(fifo_level), 64'd3);
        check("bp_overflow", 64'(overflow), 64'd0);
        check("bp_valid", 64'(dout_valid), 64'd1);
        check("bp_dout", 64'(dout), 64'(beat(words[0], 0)));
        tick();
        check("bp_dout_held", 64'(dout), 64'(beat(words[0], 0)));
        dout_ready = 1'b1;
        drain(0, 4, "bp");

        // Overflow: six words, the sixth is dropped.
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) strobe(words[i]);
        check("ovf_level_5", 64'(fifo_level), 64'd4);
        check("ovf_flag_5", 64'(overflow), 64'd0);
        strobe(words[5]);
        check("ovf_level_6", 64'(fifo_level), 64'd4);
        check("ovf_flag_6", 64'(overflow), 64'd1);
        tick();
        check("ovf_sticky", 64'(overflow), 64'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);
        dout_ready = 1'b1;
        drain(0, 5, "ovf");

        // Drop and clear in the same cycle: set wins.
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) strobe(words[i]);
        check("swc_flag_before", 64'(overflow), 64'd0);
        clear_overflow = 1'b1;
        strobe(words[5]);
        clear_overflow = 1'b0;
        check("swc_flag", 64'(overflow), 64'd1);
        check("swc_level", 64'(fifo_level), 64'd4);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("swc_cleared", 64'(overflow), 64'd0);
        dout_ready = 1'b1;
        drain(0, 5, "swc");

        // Reset while in SECOND with two words buffered.
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) strobe(words[i]);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("rmid_level", 64'(fifo_level), 64'd2);
        check("rmid_dout", 64'(dout), 64'(beat(words[0], 1)));
        #2;
        reset = 1'b0;
        #1;
        check("rmid_valid_async", 64'(dout_valid), 64'd0);
        check("rmid_level_async", 64'(fifo_level), 64'd0);
        check("rmid_dout_async", 64'(dout), 64'd0);
        #2;
        reset = 1'b1;
        tick();
        dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rmid_no_stale_%0d", i), 64'(dout_valid), 64'd0);
        end
        check("rmid_level_post", 64'(fifo_level), 64'd0);
        run_single("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/word_splitter.md
# word_splitter

Downstream stage of the 64-bit data generation path. It accepts 64-bit words from the half-swapping stage as single-cycle strobes without backpressure, buffers them in a small FIFO, and serialises each word into two 32-bit beats on a valid/ready interface toward the 32-bit pipe-out logic. It also reports FIFO occupancy and a sticky overflow flag for words dropped while the buffer is full.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in 64-bit entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- din  input  64  input word from the upstream swap stage.
- din_available  input  1  single-cycle strobe; din is valid in this cycle.
- dout  output  32  output beat.
- dout_valid  output  1  dout holds a valid beat.
- dout_ready  input  1  consumer accepts the beat when dout_valid && dout_ready.
- fifo_level  output  $clog2(DEPTH)+1  number of occupied FIFO entries; excludes the word in the hold register.
- overflow  output  1  sticky flag; a word was dropped.
- clear_overflow  input  1  synchronous clear of overflow.

## Operation
- **Write.** On din_available && (fifo_level != DEPTH), din is written at the tail.
- **Drop on full.** On din_available && fifo_level == DEPTH, the word is dropped and overflow is set. This applies even if a pop happens in the same cycle, because "full" is judged on the registered level.
- **Output FSM.** States are IDLE, FIRST and SECOND. A 64-bit hold register stores the word currently being serialised.
  - IDLE, FIFO non-empty: pop the head into hold; dout = head[31:0]; dout_valid = 1; go to FIRST.
  - IDLE, FIFO empty: stay in IDLE; dout_valid = 0.
  - FIRST && dout_ready: dout = hold[63:32]; go to SECOND.
  - FIRST && !dout_ready: hold dout and dout_valid unchanged.
  - SECOND && dout_ready, FIFO non-empty: pop the next word; dout = next[31:0]; go to FIRST. There is no bubble.
  - SECOND && dout_ready, FIFO empty: dout_valid = 0; go to IDLE.
  - SECOND && !dout_ready: hold.
- **Beat order.** The low half is sent first (default).
- **dout when invalid.** When dout_valid = 0, dout retains its last value (zero after reset).
- **Level arithmetic.** Write and pop in the same cycle leave fifo_level unchanged. Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
- **clear_overflow.** Clears overflow at the next edge. If a drop occurs in the same cycle, overflow stays 1 (set wins).
- **Reset values.** dout = 0, dout_valid = 0, fifo_level = 0, overflow = 0, FSM = IDLE, FIFO pointers = 0, hold = 0.
- **Reset mid-operation.** In-flight and buffered words are discarded; nothing is replayed after reset.

## Timing
- Strobe-to-output latency: din_available in cycle N gives dout_valid = 1 with the low half in cycle N+2, when the FIFO and FSM are idle.
- The second beat follows the first one cycle after the first beat is accepted.
- Sustained throughput is one 32-bit beat per cycle with dout_ready held high. The input can therefore sustain one word every 2 cycles without loss.
- fifo_level updates one cycle after the write or pop edge, i.e. it is registered.
- overflow rises in cycle N+1 for a drop in cycle N.

## Configuration
- Macro: WORD_SPLITTER_HIGH_FIRST_EN.
- Defined: the FIRST beat is hold[63:32] and the SECOND beat is hold[31:0], i.e. the high half is sent first.
- Undefined: the low half is sent first, as described above.
- All other behaviour and timing are identical in both builds.

## Structure
- Package word_splitter_pkg holds:
  - the FSM state typedef (IDLE, FIRST, SECOND);
  - localparams IN_W = 64 and OUT_W = 32.
- Sub-module word_splitter_fifo: synchronous FIFO (DEPTH × IN_W) with push, pop, head data, level, and full/empty outputs, on the same clk and reset.
- The top level contains the FSM, hold register, overflow logic and the macro-selected beat mux.

## Test plan
- **Single word.** After reset release, strobe din = 64'h11223344_AABBCCDD once with dout_ready = 1 → dout = 32'hAABBCCDD valid in cycle N+2, then 32'h11223344 in N+3, then dout_valid = 0 in N+4; fifo_level never exceeds 1.
- **Backpressure.** dout_ready = 0, strobe 4 words (DEPTH = 4) → the first word moves to hold and fifo_level reaches 3 with overflow = 0. With dout_ready high, all 8 beats arrive in order with no gaps.
- **Overflow.** dout_ready = 0, strobe 6 words → fifo_level = 4 and overflow = 1 after the 6th word. Pulsing clear_overflow gives overflow = 0. With dout_ready high, only words 1–5 appear.
- **Set beats clear.** clear_overflow asserted in the same cycle as a drop → overflow remains 1.
- **Reset mid-operation.** Assert reset during SECOND with 2 words buffered → dout_valid = 0 and fifo_level = 0 immediately. After release, no stale beats appear.
- **Macro build.** With WORD_SPLITTER_HIGH_FIRST_EN defined, rerun the single-word test → 32'h11223344 is sent first, then 32'hAABBCCDD.
